// File: rtl/mem_responder.sv
// mem_responder: single-port 256 x 8 memory that answers chip-select requests
// after a fixed number of wait cycles, with a side-band preload port.
//
// Ports
//   clock, reset         rising-edge clock, asynchronous active-high reset
//   mem_cs (active low)  request pending; mem_wr selects write (1) / read (0)
//   address, data_in     request address and write data (latched on accept)
//   load_en/addr/data    preload write, honoured only while idle
//   data_out             read data, valid with ready, held until next read
//   ready                one-cycle completion strobe per accepted request
//   busy                 high whenever the responder is not idle
//   rd_count, wr_count   completed reads / writes, saturating at 255
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for a request (mem_cs low) or a preload strobe
// S_BUSY   | wait cycles running against the latched request
// S_DONE   | access committed, ready high for this cycle
// S_RELEASE| waiting for mem_cs to return high before accepting again
module mem_responder #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       mem_cs,
  input  logic       mem_wr,
  input  logic [7:0] address,
  input  logic [7:0] data_in,
  input  logic       load_en,
  input  logic [7:0] load_addr,
  input  logic [7:0] load_data,
  output logic [7:0] data_out,
  output logic       ready,
  output logic       busy,
  output logic [7:0] rd_count,
  output logic [7:0] wr_count
);

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY    = 2'd1,
    S_DONE    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] wait_q, wait_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       wr_q, wr_d;
  logic [7:0] data_out_q, data_out_d;
  logic [7:0] rd_cnt_q, rd_cnt_d;
  logic [7:0] wr_cnt_q, wr_cnt_d;
  logic       ready_q, ready_d;
  logic       busy_q, busy_d;

  logic [7:0] mem_q [256];
  logic       enter_done;
  logic       load_we;
  logic       mem_we;
  logic [7:0] mem_waddr;
  logic [7:0] mem_wdata;

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wr_d       = wr_q;
    data_out_d = data_out_q;
    rd_cnt_d   = rd_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    enter_done = 1'b0;
    load_we    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A preload in the same cycle as a request wins; the request is
        // simply seen again on the next edge.
        if (load_en) begin
          load_we = 1'b1;
        end else if (!mem_cs) begin
          addr_d  = address;
          wr_d    = mem_wr;
          wdata_d = data_in;
          wait_d  = 4'd0;
          if (WAIT_CYCLES == 0) begin
            state_d    = S_DONE;
            enter_done = 1'b1;
          end else begin
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        wait_d = wait_q + 4'd1;
        if (wait_q == WAIT_LAST) begin
          state_d    = S_DONE;
          enter_done = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_RELEASE;
        if (wr_q) begin
          if (wr_cnt_q != 8'hFF) wr_cnt_d = wr_cnt_q + 8'd1;
        end else begin
          if (rd_cnt_q != 8'hFF) rd_cnt_d = rd_cnt_q + 8'd1;
        end
      end
      S_RELEASE: begin
        if (mem_cs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // addr_d/wr_d are the latched request on the entering edge, which also
    // covers the zero-wait case where latch and completion share an edge.
    if (enter_done && !wr_d) data_out_d = mem_q[addr_d];

    ready_d = (state_d == S_DONE);
    busy_d  = (state_d != S_IDLE);

    // Gated by reset so an aborted access never reaches the array.
    mem_we    = !reset && (load_we || (enter_done && wr_d));
    mem_waddr = load_we ? load_addr : addr_d;
    mem_wdata = load_we ? load_data : wdata_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wait_q     <= 4'd0;
      addr_q     <= 8'h00;
      wdata_q    <= 8'h00;
      wr_q       <= 1'b0;
      data_out_q <= 8'h00;
      rd_cnt_q   <= 8'h00;
      wr_cnt_q   <= 8'h00;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wr_q       <= wr_d;
      data_out_q <= data_out_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign data_out = data_out_q;
  assign ready    = ready_q;
  assign busy     = busy_q;
  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: one instance with 2 wait cycles (index 0) and one
// with zero wait cycles (index 1). Directed table, hand-written corner cases
// and random traffic checked against a simple array/counter model.
module tb_mem_responder;

  logic       clock = 1'b0;
  logic       reset;
  logic       cs_i   [2];
  logic       wr_i   [2];
  logic       ld_i   [2];
  logic [7:0] addr_i [2];
  logic [7:0] din_i  [2];
  logic [7:0] la_i   [2];
  logic [7:0] lv_i   [2];
  logic [7:0] do_o   [2];
  logic       rdy_o  [2];
  logic       busy_o [2];
  logic [7:0] rc_o   [2];
  logic [7:0] wc_o   [2];

  int passed = 0;
  int total  = 0;

  // reference model
  logic [7:0] m_mem   [2][256];
  bit         m_known [2][256];
  logic [7:0] m_do    [2];
  int         m_rd    [2];
  int         m_wr    [2];

  typedef struct {
    bit         ld;
    bit         wr;
    logic [7:0] addr;
    logic [7:0] data;
    int         hold;
    logic [7:0] exp_do;
    int         exp_rd;
    int         exp_wr;
  } vec_t;

  vec_t tbl [11];

  mem_responder #(.WAIT_CYCLES(2)) dut_w2 (
    .clock(clock), .reset(reset), .mem_cs(cs_i[0]), .mem_wr(wr_i[0]),
    .address(addr_i[0]), .data_in(din_i[0]), .load_en(ld_i[0]),
    .load_addr(la_i[0]), .load_data(lv_i[0]), .data_out(do_o[0]),
    .ready(rdy_o[0]), .busy(busy_o[0]), .rd_count(rc_o[0]), .wr_count(wc_o[0])
  );

  mem_responder #(.WAIT_CYCLES(0)) dut_w0 (
    .clock(clock), .reset(reset), .mem_cs(cs_i[1]), .mem_wr(wr_i[1]),
    .address(addr_i[1]), .data_in(din_i[1]), .load_en(ld_i[1]),
    .load_addr(la_i[1]), .load_data(lv_i[1]), .data_out(do_o[1]),
    .ready(rdy_o[1]), .busy(busy_o[1]), .rd_count(rc_o[1]), .wr_count(wc_o[1])
  );

  always #5 clock = ~clock;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // negedges from driving a request until ready is seen: request sampled at
  // edge t0, DONE entered at t0+W+1 (or at t0 itself with zero wait)
  function automatic int exp_lat(input int d);
    return (d == 0) ? 2 + 2 : 1;
  endfunction

  function automatic void model_reset(input int d);
    m_do[d] = 8'h00;
    m_rd[d] = 0;
    m_wr[d] = 0;
  endfunction

  function automatic void model_access(input int d, input bit w,
                                       input logic [7:0] a, input logic [7:0] v);
    if (w) begin
      m_mem[d][a]   = v;
      m_known[d][a] = 1'b1;
      m_wr[d]       = (m_wr[d] >= 255) ? 255 : m_wr[d] + 1;
    end else begin
      m_do[d] = m_mem[d][a];
      m_rd[d] = (m_rd[d] >= 255) ? 255 : m_rd[d] + 1;
    end
  endfunction

  task automatic preload(input int d, input logic [7:0] a, input logic [7:0] v);
    @(negedge clock);
    ld_i[d] = 1'b1;
    la_i[d] = a;
    lv_i[d] = v;
    @(negedge clock);
    ld_i[d] = 1'b0;
    m_mem[d][a]   = v;
    m_known[d][a] = 1'b1;
  endtask

  task automatic access_start(input int d, input bit w, input logic [7:0] a,
                              input logic [7:0] v);
    @(negedge clock);
    cs_i[d]   = 1'b0;
    wr_i[d]   = w;
    addr_i[d] = a;
    din_i[d]  = v;
  endtask

  // Completes a request already driven; checks latency, single ready pulse,
  // busy while chip select is held, and return to idle; updates the model.
  task automatic run_access(input int d, input bit w, input logic [7:0] a,
                            input logic [7:0] v, input int hold, input bit ld_junk);
    int lat;
    int extra;
    bit busy_ok;
    bit idle;
    lat = -1; extra = 0; busy_ok = 1'b1; idle = 1'b0;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(negedge clock);
      if (rdy_o[d]) begin
        lat = k;
      end else begin
        if (!busy_o[d]) busy_ok = 1'b0;
        addr_i[d] = 8'($urandom);
        din_i[d]  = 8'($urandom);
        wr_i[d]   = 1'($urandom);
        if (ld_junk && k == 1) begin
          ld_i[d] = 1'b1;
          la_i[d] = a;
          lv_i[d] = ~m_mem[d][a];
        end else begin
          ld_i[d] = 1'b0;
        end
      end
    end
    ld_i[d] = 1'b0;
    check($sformatf("latency[%0d]", d), lat, exp_lat(d));
    for (int k = 0; k < hold; k++) begin
      @(negedge clock);
      if (rdy_o[d]) extra++;
      if (!busy_o[d]) busy_ok = 1'b0;
    end
    cs_i[d] = 1'b1;
    for (int k = 0; k < 4 && !idle; k++) begin
      @(negedge clock);
      if (rdy_o[d]) extra++;
      if (!busy_o[d]) idle = 1'b1;
    end
    check($sformatf("ready_single[%0d]", d), extra, 0);
    check($sformatf("busy_hold[%0d]", d), int'(busy_ok), 1);
    check($sformatf("release_idle[%0d]", d), int'(idle), 1);
    model_access(d, w, a, v);
  endtask

  task automatic do_access(input int d, input bit w, input logic [7:0] a,
                           input logic [7:0] v, input int hold);
    access_start(d, w, a, v);
    run_access(d, w, a, v, hold, 1'b0);
  endtask

  task automatic check_model(input int d, input string tag);
    check($sformatf("%s data_out[%0d]", tag, d), int'(do_o[d]), int'(m_do[d]));
    check($sformatf("%s rd_count[%0d]", tag, d), int'(rc_o[d]), m_rd[d]);
    check($sformatf("%s wr_count[%0d]", tag, d), int'(wc_o[d]), m_wr[d]);
  endtask

  task automatic check_reset_vals(input int d, input string tag);
    check($sformatf("%s ready[%0d]", tag, d), int'(rdy_o[d]), 0);
    check($sformatf("%s busy[%0d]", tag, d), int'(busy_o[d]), 0);
    check($sformatf("%s data_out[%0d]", tag, d), int'(do_o[d]), 0);
    check($sformatf("%s rd_count[%0d]", tag, d), int'(rc_o[d]), 0);
    check($sformatf("%s wr_count[%0d]", tag, d), int'(wc_o[d]), 0);
  endtask

  initial begin
    logic [7:0] a, v;
    bit w;

    tbl[0]  = '{1'b1, 1'b0, 8'h10, 8'hA5, 0,  8'h00, 0, 0};
    tbl[1]  = '{1'b0, 1'b0, 8'h10, 8'h00, 0,  8'hA5, 1, 0};
    tbl[2]  = '{1'b0, 1'b1, 8'h20, 8'h3C, 0,  8'hA5, 1, 1};
    tbl[3]  = '{1'b0, 1'b0, 8'h20, 8'h00, 0,  8'h3C, 2, 1};
    tbl[4]  = '{1'b0, 1'b0, 8'h10, 8'h00, 10, 8'hA5, 3, 1};
    tbl[5]  = '{1'b0, 1'b1, 8'h10, 8'h77, 3,  8'hA5, 3, 2};
    tbl[6]  = '{1'b0, 1'b0, 8'h10, 8'h00, 0,  8'h77, 4, 2};
    tbl[7]  = '{1'b1, 1'b0, 8'hFF, 8'h80, 0,  8'h00, 0, 0};
    tbl[8]  = '{1'b0, 1'b0, 8'hFF, 8'h00, 1,  8'h80, 5, 2};
    tbl[9]  = '{1'b0, 1'b1, 8'h00, 8'h5A, 0,  8'h80, 5, 3};
    tbl[10] = '{1'b0, 1'b0, 8'h00, 8'h00, 0,  8'h5A, 6, 3};

    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      cs_i[d] = 1'b1; wr_i[d] = 1'b0; ld_i[d] = 1'b0;
      addr_i[d] = 8'h00; din_i[d] = 8'h00; la_i[d] = 8'h00; lv_i[d] = 8'h00;
      model_reset(d);
      for (int i = 0; i < 256; i++) begin
        m_mem[d][i] = 8'h00; m_known[d][i] = 1'b0;
      end
    end
    repeat (3) @(negedge clock);
    check_reset_vals(0, "por");
    check_reset_vals(1, "por");
    reset = 1'b0;

    // directed table on the 2-wait-cycle instance
    for (int i = 0; i < 11; i++) begin
      if (tbl[i].ld) begin
        preload(0, tbl[i].addr, tbl[i].data);
      end else begin
        do_access(0, tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].hold);
        check($sformatf("tbl%0d data_out", i), int'(do_o[0]), int'(tbl[i].exp_do));
        check($sformatf("tbl%0d rd_count", i), int'(rc_o[0]), tbl[i].exp_rd);
        check($sformatf("tbl%0d wr_count", i), int'(wc_o[0]), tbl[i].exp_wr);
      end
    end

    // preload attempt while busy must be ignored
    access_start(0, 1'b0, 8'h20, 8'h00);
    run_access(0, 1'b0, 8'h20, 8'h00, 0, 1'b1);
    check_model(0, "ld_ignored");

    // random traffic against the model
    for (int i = 0; i < 60; i++) begin
      a = 8'($urandom_range(0, 31));
      if (!m_known[0][a]) preload(0, a, 8'($urandom));
      w = 1'($urandom_range(0, 1));
      v = 8'($urandom);
      do_access(0, w, a, v, $urandom_range(0, 3));
      check_model(0, "rand");
    end

    // reset during BUSY of a write aborts it
    preload(0, 8'h40, 8'h11);
    access_start(0, 1'b1, 8'h40, 8'hFF);
    repeat (2) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check_reset_vals(0, "async_rst");
    cs_i[0] = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    model_reset(0);
    model_reset(1);
    do_access(0, 1'b0, 8'h40, 8'h00, 0);
    check("abort read 0x40", int'(do_o[0]), 8'h11);
    check_model(0, "abort");

    // request pending across reset release is accepted on the first edge
    @(negedge clock);
    reset   = 1'b1;
    cs_i[0] = 1'b0; wr_i[0] = 1'b0; addr_i[0] = 8'h40;
    @(negedge clock);
    reset = 1'b0;
    model_reset(0);
    run_access(0, 1'b0, 8'h40, 8'h00, 0, 1'b0);
    check_model(0, "post_rst");

    // preload and request in the same idle cycle: preload first
    @(negedge clock);
    ld_i[0] = 1'b1; la_i[0] = 8'h08; lv_i[0] = 8'h55;
    cs_i[0] = 1'b0; wr_i[0] = 1'b0; addr_i[0] = 8'h08;
    @(negedge clock);
    ld_i[0] = 1'b0;
    m_mem[0][8'h08] = 8'h55; m_known[0][8'h08] = 1'b1;
    check("collide deferred busy", int'(busy_o[0]), 0);
    run_access(0, 1'b0, 8'h08, 8'h00, 0, 1'b0);
    check("collide read 0x08", int'(do_o[0]), 8'h55);
    check_model(0, "collide");

    // zero-wait instance: back-to-back reads through counter saturation
    for (int i = 0; i < 8; i++) preload(1, 8'(i), 8'(i * 17 + 3));
    do_access(1, 1'b1, 8'h03, 8'hC3, 0);
    do_access(1, 1'b1, 8'h06, 8'h96, 0);
    check_model(1, "w0_wr");
    for (int i = 0; i < 256; i++) begin
      do_access(1, 1'b0, 8'(i % 8), 8'h00, 0);
      check($sformatf("w0 read %0d data", i), int'(do_o[1]), int'(m_do[1]));
      check($sformatf("w0 read %0d rd_count", i), int'(rc_o[1]), m_rd[1]);
    end
    check("w0 rd_count saturated", int'(rc_o[1]), 255);
    do_access(1, 1'b1, 8'h01, 8'h44, 0);
    do_access(1, 1'b0, 8'h01, 8'h00, 0);
    check("w0 read after sat", int'(do_o[1]), 8'h44);
    check_model(1, "w0_end");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
